arr_out_deskew: RTL and testbench

ARR_OUT_DESKEW -- requirements
Module: arr_out_deskew

---
 rtl/arr_out_deskew_if.sv | 28 ++
 rtl/arr_out_deskew.sv | 121 ++++++++++++
 tb/tb_arr_out_deskew.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arr_out_deskew_if.sv
// Bus between the 4x4 array output columns, the deskew block and the row consumer.
// The environment (array plus consumer) takes the master side and the deskew block takes the slave side.
interface arr_out_deskew_if #(
   parameter int unsigned CW    = 24,
   parameter int unsigned DEPTH = 4
);
   logic                     in_vld;
   logic [CW-1:0]            c1_out;
   logic [CW-1:0]            c2_out;
   logic [CW-1:0]            c3_out;
   logic [CW-1:0]            c4_out;
   logic [4*CW-1:0]          out_data;
   logic [7:0]               out_idx;
   logic                     out_vld;
   logic                     out_rdy;
   logic [$clog2(DEPTH):0]   fifo_cnt;
   logic                     drop_err;

   modport master (
      output in_vld, c1_out, c2_out, c3_out, c4_out, out_rdy,
      input  out_data, out_idx, out_vld, fifo_cnt, drop_err
   );

   modport slave (
      input  in_vld, c1_out, c2_out, c3_out, c4_out, out_rdy,
      output out_data, out_idx, out_vld, fifo_cnt, drop_err
   );
endinterface

// File: rtl/arr_out_deskew.sv
// Realigns the skewed column outputs of a 4x4 array into whole rows and queues
// each row with its index in a first-word-fall-through result FIFO.
module arr_out_deskew #(
   parameter int unsigned LAT   = 4,
   parameter int unsigned CW    = 24,
   parameter int unsigned DEPTH = 4
) (
   input logic             clk,
   input logic             rst_n,
   input logic             flush,
   input logic             err_clr,
   arr_out_deskew_if.slave bus
);
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned NTRK = LAT + 3;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef logic [4*CW-1:0]   row_t;
   typedef logic [4*CW+7:0]   entry_t;

   logic [NTRK-1:0]      trk;
   logic [2:0][CW-1:0]   h1;
   logic [1:0][CW-1:0]   h2;
   logic [CW-1:0]        h3;

   entry_t               mem [DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW:0]          cnt;
   logic [7:0]           wr_idx;
   logic                 drop_err_q;

   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 empty;
   logic                 do_push;
   logic                 drop;
   row_t                 row;
   entry_t               head;

   always_comb begin
      push    = trk[NTRK-1];
      full    = (cnt == FULL_CNT);
      empty   = (cnt == '0);
      pop     = !empty && bus.out_rdy;
      // a pop frees the head slot in the same edge, so a full FIFO can still take a row
      do_push = push && (!full || pop) && !flush;
      drop    = push && full && !pop && !flush;
      row     = {bus.c4_out, h3, h2[1], h1[2]};
      head    = mem[rd_ptr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trk    <= '0;
         h1     <= '0;
         h2     <= '0;
         h3     <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         wr_idx <= '0;
      end else if (flush) begin
         trk    <= '0;
         h1     <= '0;
         h2     <= '0;
         h3     <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         wr_idx <= '0;
      end else begin
         trk <= {trk[NTRK-2:0], bus.in_vld};

         // early columns ride along with their row until c4 arrives
         h1[0] <= trk[LAT-1] ? bus.c1_out : '0;
         h1[1] <= h1[0];
         h1[2] <= h1[1];
         h2[0] <= trk[LAT]   ? bus.c2_out : '0;
         h2[1] <= h2[0];
         h3    <= trk[LAT+1] ? bus.c3_out : '0;

         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
            wr_idx <= wr_idx + 8'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= {wr_idx, row};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_err_q <= 1'b0;
      end else if (drop) begin
         drop_err_q <= 1'b1;
      end else if (err_clr) begin
         drop_err_q <= 1'b0;
      end
   end

   assign bus.out_vld  = !empty;
   assign bus.out_data = empty ? '0 : head[4*CW-1:0];
   assign bus.out_idx  = empty ? '0 : head[4*CW+7:4*CW];
   assign bus.fifo_cnt = cnt;
   assign bus.drop_err = drop_err_q;

endmodule

// File: tb/tb_arr_out_deskew.sv
// Bench for arr_out_deskew: an array emulator drives skewed columns, and a scoreboard
// queue holds the rows expected at the output.
module tb_arr_out_deskew;
   localparam int unsigned LAT   = 4;
   localparam int unsigned CW    = 24;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned NDL   = LAT + 3;

   typedef logic [4*CW-1:0] row_t;
   typedef struct packed {
      row_t       data;
      logic [7:0] idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic err_clr = 1'b0;

   arr_out_deskew_if #(.CW(CW), .DEPTH(DEPTH)) bus ();

   arr_out_deskew #(.LAT(LAT), .CW(CW), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .err_clr (err_clr),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   exp_t        exp_q[$];
   logic [7:0]  next_idx = '0;
   row_t        cur_row = '0;

   // array emulator: column k of a row appears LAT+k-1 cycles after in_vld, junk otherwise
   logic [NDL-1:0] dv = '0;
   row_t           dd [NDL];
   row_t           junk = '0;

   always @(posedge clk) begin
      dv    <= {dv[NDL-2:0], bus.in_vld};
      dd[0] <= cur_row;
      for (int i = 1; i < NDL; i++) dd[i] <= dd[i-1];
      junk  <= row_t'({$urandom, $urandom, $urandom, $urandom});
   end

   assign bus.c1_out = dv[LAT-1] ? dd[LAT-1][CW-1:0]      : junk[CW-1:0];
   assign bus.c2_out = dv[LAT]   ? dd[LAT][2*CW-1:CW]     : junk[2*CW-1:CW];
   assign bus.c3_out = dv[LAT+1] ? dd[LAT+1][3*CW-1:2*CW] : junk[3*CW-1:2*CW];
   assign bus.c4_out = dv[LAT+2] ? dd[LAT+2][4*CW-1:3*CW] : junk[4*CW-1:3*CW];

   always @(negedge clk) begin
      if (rst_n && bus.out_vld && bus.out_rdy) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: out_data=%0h out_idx=%0d with no row expected", bus.out_data, bus.out_idx);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.out_data !== e.data)
               $display("FAIL sb_data: got %0h expected %0h", bus.out_data, e.data);
            else n_pass++;
            n_checks++;
            if (bus.out_idx !== e.idx)
               $display("FAIL sb_idx: got %0d expected %0d", bus.out_idx, e.idx);
            else n_pass++;
         end
      end
   end

   function automatic row_t mk_row(input int unsigned a, input int unsigned b,
                                   input int unsigned c, input int unsigned d);
      return {CW'(d), CW'(c), CW'(b), CW'(a)};
   endfunction

   task automatic launch(input row_t r, input bit kept);
      exp_t e;
      bus.in_vld = 1'b1;
      cur_row = r;
      if (kept) begin
         e.data = r;
         e.idx = next_idx;
         exp_q.push_back(e);
         next_idx++;
      end
      @(posedge clk); #1;
      bus.in_vld = 1'b0;
   endtask

   task automatic do_reset();
      bus.in_vld = 1'b0;
      bus.out_rdy = 1'b0;
      flush = 1'b0;
      err_clr = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      next_idx = '0;
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input int unsigned max_cyc);
      for (int unsigned i = 0; i < max_cyc && exp_q.size() != 0; i++) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.in_vld = 1'b0;
      bus.out_rdy = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.out_vld !== 1'b0) $display("FAIL rst_out_vld: got %0b expected 0", bus.out_vld); else n_pass++;
      n_checks++; if (bus.out_data !== '0) $display("FAIL rst_out_data: got %0h expected 0", bus.out_data); else n_pass++;
      n_checks++; if (bus.out_idx !== 8'd0) $display("FAIL rst_out_idx: got %0d expected 0", bus.out_idx); else n_pass++;
      n_checks++; if (bus.fifo_cnt !== '0) $display("FAIL rst_fifo_cnt: got %0d expected 0", bus.fifo_cnt); else n_pass++;
      n_checks++; if (bus.drop_err !== 1'b0) $display("FAIL rst_drop_err: got %0b expected 0", bus.drop_err); else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int unsigned early = 0;
      bus.out_rdy = 1'b1;
      launch(mk_row('h11, 'h22, 'h33, 'h44), 1'b1);
      repeat (7) begin
         @(negedge clk);
         if (bus.out_vld) early++;
      end
      n_checks++; if (early !== 0) $display("FAIL single_early: got %0d early cycles expected 0", early); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.out_vld !== 1'b1) $display("FAIL single_vld_lat: got %0b expected 1", bus.out_vld); else n_pass++;
      n_checks++; if (bus.out_data !== 96'h000044_000033_000022_000011)
         $display("FAIL single_data: got %0h expected 000044000033000022000011", bus.out_data); else n_pass++;
      n_checks++; if (bus.out_idx !== 8'd0) $display("FAIL single_idx: got %0d expected 0", bus.out_idx); else n_pass++;
      wait_drain(10);
      n_checks++; if (exp_q.size() != 0) $display("FAIL single_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int unsigned early = 0;
      int unsigned vld_cnt = 0;
      do_reset();
      bus.out_rdy = 1'b1;
      for (int unsigned r = 0; r < 4; r++)
         launch(mk_row(16*r+1, 16*r+2, 16*r+3, 16*r+4), 1'b1);
      repeat (4) begin
         @(negedge clk);
         if (bus.out_vld) early++;
      end
      repeat (4) begin
         @(negedge clk);
         if (bus.out_vld) vld_cnt++;
      end
      n_checks++; if (early !== 0) $display("FAIL b2b_early: got %0d early cycles expected 0", early); else n_pass++;
      n_checks++; if (vld_cnt !== 4) $display("FAIL b2b_vld_cycles: got %0d expected 4", vld_cnt); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.out_vld !== 1'b0) $display("FAIL b2b_vld_end: got %0b expected 0", bus.out_vld); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_backpressure();
      int unsigned bad = 0;
      do_reset();
      bus.out_rdy = 1'b0;
      for (int unsigned r = 0; r < 6; r++)
         launch(mk_row('h100+16*r+1, 'h100+16*r+2, 'h100+16*r+3, 'h100+16*r+4), r < 4);
      repeat (6) @(posedge clk);
      #1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.fifo_cnt !== 3'd4) $display("FAIL bp_fifo_cnt: got %0d expected 4", bus.fifo_cnt); else n_pass++;
      n_checks++; if (bus.drop_err !== 1'b1) $display("FAIL bp_drop_clr_race: got %0b expected 1", bus.drop_err); else n_pass++;
      repeat (3) begin
         @(negedge clk);
         if (bus.out_data !== mk_row('h101, 'h102, 'h103, 'h104) || bus.out_idx !== 8'd0 || !bus.out_vld) bad++;
      end
      n_checks++; if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); else n_pass++;
      @(posedge clk); #1;
      bus.out_rdy = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.fifo_cnt !== 3'd4) $display("FAIL bp_cnt_pop_cycle: got %0d expected 4", bus.fifo_cnt); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.fifo_cnt !== 3'd3) $display("FAIL bp_cnt_after_pop: got %0d expected 3", bus.fifo_cnt); else n_pass++;
      wait_drain(20);
      n_checks++; if (exp_q.size() != 0) $display("FAIL bp_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.fifo_cnt !== '0) $display("FAIL bp_cnt_empty: got %0d expected 0", bus.fifo_cnt); else n_pass++;
      n_checks++; if (bus.drop_err !== 1'b1) $display("FAIL bp_sticky: got %0b expected 1", bus.drop_err); else n_pass++;
      @(posedge clk); #1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.drop_err !== 1'b0) $display("FAIL bp_err_clr: got %0b expected 0", bus.drop_err); else n_pass++;
   endtask

   task automatic test_full_pop();
      do_reset();
      bus.out_rdy = 1'b0;
      for (int unsigned r = 0; r < 5; r++)
         launch(mk_row('h200+16*r+1, 'h200+16*r+2, 'h200+16*r+3, 'h200+16*r+4), 1'b1);
      repeat (6) @(posedge clk);
      #1;
      bus.out_rdy = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.fifo_cnt !== 3'd4) $display("FAIL fp_full: got %0d expected 4", bus.fifo_cnt); else n_pass++;
      @(posedge clk); #1;
      bus.out_rdy = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.fifo_cnt !== 3'd4) $display("FAIL fp_cnt_kept: got %0d expected 4", bus.fifo_cnt); else n_pass++;
      n_checks++; if (bus.drop_err !== 1'b0) $display("FAIL fp_no_drop: got %0b expected 0", bus.drop_err); else n_pass++;
      @(posedge clk); #1;
      bus.out_rdy = 1'b1;
      wait_drain(20);
      n_checks++; if (exp_q.size() != 0) $display("FAIL fp_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_reset_midstream();
      int unsigned stray = 0;
      int unsigned early = 0;
      do_reset();
      bus.out_rdy = 1'b1;
      for (int unsigned r = 0; r < 3; r++)
         launch(mk_row('h300+r, 'h310+r, 'h320+r, 'h330+r), 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      next_idx = '0;
      repeat (20) begin
         @(negedge clk);
         if (bus.out_vld) stray++;
      end
      n_checks++; if (stray !== 0) $display("FAIL rm_stray: got %0d out_vld cycles expected 0", stray); else n_pass++;
      @(posedge clk); #1;
      launch(mk_row('h3a1, 'h3a2, 'h3a3, 'h3a4), 1'b1);
      repeat (7) begin
         @(negedge clk);
         if (bus.out_vld) early++;
      end
      n_checks++; if (early !== 0) $display("FAIL rm_early: got %0d early cycles expected 0", early); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.out_vld !== 1'b1) $display("FAIL rm_new_row: got %0b expected 1", bus.out_vld); else n_pass++;
      wait_drain(10);
      n_checks++; if (exp_q.size() != 0) $display("FAIL rm_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_flush();
      int unsigned stray = 0;
      do_reset();
      bus.out_rdy = 1'b0;
      for (int unsigned r = 0; r < 5; r++)
         launch(mk_row('h400+r, 'h410+r, 'h420+r, 'h430+r), 1'b0);
      repeat (7) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.drop_err !== 1'b1) $display("FAIL fl_pre_drop: got %0b expected 1", bus.drop_err); else n_pass++;
      @(posedge clk); #1;
      launch(mk_row('h4f1, 'h4f2, 'h4f3, 'h4f4), 1'b0);
      flush = 1'b1;
      err_clr = 1'b1;
      bus.in_vld = 1'b1;
      cur_row = mk_row('h4e1, 'h4e2, 'h4e3, 'h4e4);
      @(posedge clk); #1;
      flush = 1'b0;
      err_clr = 1'b0;
      bus.in_vld = 1'b0;
      next_idx = '0;
      @(negedge clk);
      n_checks++; if (bus.fifo_cnt !== '0) $display("FAIL fl_cnt: got %0d expected 0", bus.fifo_cnt); else n_pass++;
      n_checks++; if (bus.out_vld !== 1'b0) $display("FAIL fl_vld: got %0b expected 0", bus.out_vld); else n_pass++;
      n_checks++; if (bus.drop_err !== 1'b0) $display("FAIL fl_drop_err: got %0b expected 0", bus.drop_err); else n_pass++;
      bus.out_rdy = 1'b1;
      repeat (15) begin
         @(negedge clk);
         if (bus.out_vld) stray++;
      end
      n_checks++; if (stray !== 0) $display("FAIL fl_stray: got %0d out_vld cycles expected 0", stray); else n_pass++;
      @(posedge clk); #1;
      launch(mk_row('h4a1, 'h4a2, 'h4a3, 'h4a4), 1'b1);
      wait_drain(15);
      n_checks++; if (exp_q.size() != 0) $display("FAIL fl_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.in_vld = 1'b0;
      bus.out_rdy = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_full_pop();
      test_reset_midstream();
      test_flush();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
